// File: rtl/bcd_convert_arbiter.sv
// bcd_convert_arbiter: one iterative shift-add-3 binary-to-BCD converter shared
// round-robin between up to four requesters over a req/ack handshake.
// Optional feature: define BCD_BLANK_EN to build the leading-zero blank mask.
module bcd_convert_arbiter #(
   parameter int unsigned WIDTH  = 9,
   parameter int unsigned DIGITS = 3,
   parameter int unsigned NREQ   = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*WIDTH-1:0]   bin_in,
   output logic [NREQ-1:0]         ack,
   output logic [4*DIGITS-1:0]     bcd_out,
   output logic                    bcd_valid,
   output logic [1:0]              bcd_owner,
   output logic                    busy,
   output logic [DIGITS-1:0]       blank
);

   localparam int unsigned BcdW = 4 * DIGITS;
   localparam int unsigned CntW = $clog2(WIDTH + 1);
   localparam int unsigned IdxW = (NREQ > 2) ? 2 : 1;

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e            state_q, state_d;
   logic [1:0]        last_q, last_d;
   logic [1:0]        owner_q, owner_d;
   logic [WIDTH-1:0]  opnd_q, opnd_d;
   logic [BcdW-1:0]   scratch_q, scratch_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [NREQ-1:0]   ack_q, ack_d;
   logic [BcdW-1:0]   bcd_q, bcd_d;
   logic              valid_q, valid_d;

   logic              grant_vld;
   logic [1:0]        grant_idx;
   logic [31:0]       cand;
   logic [BcdW-1:0]   adj;
   logic [BcdW-1:0]   shifted;
   logic              load_res;

   // Round-robin search starting just after the last owner.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int unsigned i = 1; i <= NREQ; i++) begin
         cand = (32'(last_q) + i) % NREQ;
         if (!grant_vld && req[cand[IdxW-1:0]]) begin
            grant_vld = 1'b1;
            grant_idx = cand[1:0];
         end
      end
   end

   // Add-3 correction on every digit >= 5, then shift in the next operand MSB.
   always_comb begin
      adj = scratch_q;
      for (int unsigned d = 0; d < DIGITS; d++) begin
         if (scratch_q[4*d +: 4] >= 4'd5) begin
            adj[4*d +: 4] = scratch_q[4*d +: 4] + 4'd3;
         end
      end
      shifted = {adj[BcdW-2:0], opnd_q[WIDTH-1]};
   end

   assign load_res = (state_q == StShift) && (cnt_q == CntW'(WIDTH - 1));

   // Next-state logic for the controller and datapath.
   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      owner_d   = owner_q;
      opnd_d    = opnd_q;
      scratch_d = scratch_q;
      cnt_d     = cnt_q;
      ack_d     = '0;
      valid_d   = 1'b0;
      bcd_d     = bcd_q;
      unique case (state_q)
         StIdle: begin
            if (grant_vld) begin
               state_d   = StShift;
               owner_d   = grant_idx;
               opnd_d    = bin_in[32'(grant_idx) * WIDTH +: WIDTH];
               scratch_d = '0;
               cnt_d     = '0;
            end
         end
         StShift: begin
            scratch_d = shifted;
            opnd_d    = opnd_q << 1;
            cnt_d     = cnt_q + CntW'(1);
            if (load_res) begin
               state_d = StDone;
               bcd_d   = shifted;
               ack_d   = NREQ'(1) << owner_q;
               valid_d = 1'b1;
               last_d  = owner_q;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         last_q    <= 2'(NREQ - 1);
         owner_q   <= '0;
         opnd_q    <= '0;
         scratch_q <= '0;
         cnt_q     <= '0;
         ack_q     <= '0;
         bcd_q     <= '0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         owner_q   <= owner_d;
         opnd_q    <= opnd_d;
         scratch_q <= scratch_d;
         cnt_q     <= cnt_d;
         ack_q     <= ack_d;
         bcd_q     <= bcd_d;
         valid_q   <= valid_d;
      end
   end

`ifdef BCD_BLANK_EN
   logic [DIGITS-1:0] blank_q, blank_d;
   logic              zero_run;

   // Blank a digit when it and every digit above it are zero; digit 0 always shows.
   always_comb begin
      blank_d  = blank_q;
      zero_run = 1'b1;
      if (load_res) begin
         blank_d = '0;
         for (int d = int'(DIGITS) - 1; d >= 1; d--) begin
            zero_run   = zero_run & (shifted[4*d +: 4] == 4'd0);
            blank_d[d] = zero_run;
         end
      end
   end

   // Blank mask register, updated together with bcd_out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blank_q <= '0;
      end else begin
         blank_q <= blank_d;
      end
   end

   assign blank = blank_q;
`else
   assign blank = '0;
`endif

   assign ack       = ack_q;
   assign bcd_out   = bcd_q;
   assign bcd_valid = valid_q;
   assign bcd_owner = owner_q;
   assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_bcd_convert_arbiter.sv
// Self-checking bench for bcd_convert_arbiter (WIDTH=9, DIGITS=3, NREQ=2).
module tb_bcd_convert_arbiter;

   localparam int WIDTH  = 9;
   localparam int DIGITS = 3;
   localparam int NREQ   = 2;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic [NREQ-1:0]       req = '0;
   logic [NREQ*WIDTH-1:0] bin_in = '0;
   logic [NREQ-1:0]       ack;
   logic [4*DIGITS-1:0]   bcd_out;
   logic                  bcd_valid;
   logic [1:0]            bcd_owner;
   logic                  busy;
   logic [DIGITS-1:0]     blank;

   int n_checks = 0;
   int n_fail   = 0;
   logic [13:0] sb_q[$];   // {owner, bcd}

   bcd_convert_arbiter #(.WIDTH(WIDTH), .DIGITS(DIGITS), .NREQ(NREQ)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .bin_in    (bin_in),
      .ack       (ack),
      .bcd_out   (bcd_out),
      .bcd_valid (bcd_valid),
      .bcd_owner (bcd_owner),
      .busy      (busy),
      .blank     (blank)
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] to_bcd(input int v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   function automatic logic [2:0] exp_blank(input logic [11:0] b);
      logic [2:0] r;
      r = 3'b000;
`ifdef BCD_BLANK_EN
      r[2] = (b[11:8] == 4'd0);
      r[1] = r[2] && (b[7:4] == 4'd0);
`endif
      return r;
   endfunction

   task automatic test_reset();
      #1;
      n_checks++;
      if (ack !== 2'b00 || bcd_out !== 12'h000 || bcd_valid !== 1'b0 || bcd_owner !== 2'd0 ||
          busy !== 1'b0 || blank !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_outputs: got ack=%b bcd=%h v=%b own=%0d busy=%b blank=%b want all 0",
                  ack, bcd_out, bcd_valid, bcd_owner, busy, blank);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // T1: cycle-exact check of a single conversion on requester 0.
   task automatic test_single();
      logic [13:0] exp;
      req[0] = 1'b1;
      bin_in[0 +: WIDTH] = 9'd255;
      sb_q.push_back({2'd0, to_bcd(255)});
      for (int k = 0; k <= 10; k++) begin
         @(negedge clk);
         n_checks++;
         if (bcd_valid !== (k == 9) || ack !== ((k == 9) ? 2'b01 : 2'b00)) begin
            n_fail++;
            $display("FAIL single_timing after edge %0d: got valid=%b ack=%b want valid=%b",
                     k, bcd_valid, ack, (k == 9));
         end
         n_checks++;
         if (busy !== (k <= 9)) begin
            n_fail++;
            $display("FAIL single_busy after edge %0d: got %b want %b", k, busy, (k <= 9));
         end
         if (k == 9) begin
            req[0] = 1'b0;
            exp = sb_q.pop_front();
            n_checks++;
            if (bcd_out !== exp[11:0] || bcd_owner !== exp[13:12]) begin
               n_fail++;
               $display("FAIL single_result: got %h owner %0d want %h owner %0d",
                        bcd_out, bcd_owner, exp[11:0], exp[13:12]);
            end
         end
      end
   endtask

   // One isolated conversion; operand is scrambled after the grant edge.
   task automatic run_one(input string name, input int k, input int v);
      logic [13:0] exp;
      int lat;
      bit got;
      req[k] = 1'b1;
      bin_in[k*WIDTH +: WIDTH] = 9'(v);
      sb_q.push_back({2'(k), to_bcd(v)});
      @(posedge clk);
      #1 bin_in[k*WIDTH +: WIDTH] = 9'($urandom);
      lat = 1;
      got = 1'b0;
      @(negedge clk);
      while (!got && lat < 40) begin
         if (bcd_valid) got = 1'b1;
         else begin
            @(negedge clk);
            lat++;
         end
      end
      n_checks++;
      if (!got || lat != 10) begin
         n_fail++;
         $display("FAIL %s latency: got %0d negedges (seen=%b) want 10", name, lat, got);
      end
      req[k] = 1'b0;
      exp = sb_q.pop_front();
      if (got) begin
         n_checks++;
         if (bcd_out !== exp[11:0] || bcd_owner !== exp[13:12]) begin
            n_fail++;
            $display("FAIL %s result: got %h owner %0d want %h owner %0d",
                     name, bcd_out, bcd_owner, exp[11:0], exp[13:12]);
         end
         n_checks++;
         if (ack !== (2'(1) << exp[13:12]) || blank !== exp_blank(exp[11:0])) begin
            n_fail++;
            $display("FAIL %s ack_blank: got ack=%b blank=%b want ack=%b blank=%b", name, ack,
                     blank, 2'(1) << exp[13:12], exp_blank(exp[11:0]));
         end
      end
      @(negedge clk);
      n_checks++;
      if (bcd_valid !== 1'b0 || ack !== 2'b00 || busy !== 1'b0 || bcd_out !== exp[11:0]) begin
         n_fail++;
         $display("FAIL %s after_done: got valid=%b ack=%b busy=%b bcd=%h want 0,00,0,%h",
                  name, bcd_valid, ack, busy, bcd_out, exp[11:0]);
      end
   endtask

   task automatic test_extremes();
      run_one("extreme_511", 1, 511);
      run_one("extreme_0", 1, 0);
      run_one("extreme_100", 1, 100);
   endtask

   // T3: both requests held from reset; req0 first, req1 granted after the dead cycle.
   task automatic test_simultaneous();
      logic [13:0] exp;
      int exp_lat[2] = '{10, 21};
      int nres = 0;
      @(negedge clk);
      rst_n = 1'b0;
      req = 2'b11;
      bin_in[0 +: WIDTH] = 9'd123;
      bin_in[WIDTH +: WIDTH] = 9'd456;
      sb_q.push_back({2'd0, to_bcd(123)});
      sb_q.push_back({2'd1, to_bcd(456)});
      @(negedge clk);
      rst_n = 1'b1;
      for (int lat = 1; lat <= 24; lat++) begin
         @(negedge clk);
         if (bcd_valid) begin
            if (nres < 2) begin
               exp = sb_q.pop_front();
               n_checks++;
               if (lat != exp_lat[nres] || bcd_out !== exp[11:0] || bcd_owner !== exp[13:12]) begin
                  n_fail++;
                  $display("FAIL simul_%0d: got lat %0d %h owner %0d want lat %0d %h owner %0d",
                           nres, lat, bcd_out, bcd_owner, exp_lat[nres], exp[11:0], exp[13:12]);
               end
               req[bcd_owner] = 1'b0;
            end
            nres++;
         end
      end
      n_checks++;
      if (nres != 2) begin
         n_fail++;
         $display("FAIL simul_count: got %0d results want 2", nres);
      end
      req = '0;
   endtask

   // T4: both requests held permanently; owners must alternate.
   task automatic test_fairness();
      logic [13:0] exp;
      int nres = 0;
      bin_in[0 +: WIDTH] = 9'd87;
      bin_in[WIDTH +: WIDTH] = 9'd432;
      for (int i = 0; i < 6; i++) begin
         if (i % 2 == 0) sb_q.push_back({2'd0, to_bcd(87)});
         else            sb_q.push_back({2'd1, to_bcd(432)});
      end
      req = 2'b11;
      for (int lat = 1; lat <= 70; lat++) begin
         @(negedge clk);
         if (bcd_valid) begin
            if (nres < 6) begin
               exp = sb_q.pop_front();
               n_checks++;
               if (bcd_owner !== exp[13:12] || bcd_out !== exp[11:0] ||
                   ack !== (2'(1) << exp[13:12])) begin
                  n_fail++;
                  $display("FAIL fair_%0d: got owner %0d %h ack %b want owner %0d %h",
                           nres, bcd_owner, bcd_out, ack, exp[13:12], exp[11:0]);
               end
            end
            nres++;
            if (nres == 6) req = '0;
         end
      end
      n_checks++;
      if (nres != 6) begin
         n_fail++;
         $display("FAIL fair_count: got %0d results want 6", nres);
      end
      req = '0;
   endtask

   // T5: asynchronous reset in the middle of a conversion.
   task automatic test_reset_mid();
      int seen = 0;
      req[0] = 1'b1;
      bin_in[0 +: WIDTH] = 9'd200;
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      n_checks++;
      if (ack !== 2'b00 || bcd_out !== 12'h000 || bcd_valid !== 1'b0 || bcd_owner !== 2'd0 ||
          busy !== 1'b0 || blank !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_mid: got ack=%b bcd=%h v=%b own=%0d busy=%b blank=%b want all 0",
                  ack, bcd_out, bcd_valid, bcd_owner, busy, blank);
      end
      req = '0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (bcd_valid || ack != 2'b00) seen++;
      end
      n_checks++;
      if (seen != 0) begin
         n_fail++;
         $display("FAIL reset_abort: got %0d ack cycles want 0", seen);
      end
      run_one("after_reset_37", 1, 37);
   endtask

   task automatic test_blank();
      run_one("blank_7", 0, 7);
      run_one("blank_0", 0, 0);
      run_one("blank_40", 0, 40);
      run_one("blank_305", 0, 305);
   endtask

   initial begin
      test_reset();
      test_single();
      test_extremes();
      test_simultaneous();
      test_fairness();
      test_reset_mid();
      test_blank();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
